i2c_slave_tx: RTL and testbench

I2C target-side transmitter. It answers master read transactions by shifting bytes onto SDA. It is the counterpart to the existing write path (master writes, slave receives).
- Decodes START/STOP, matches the 7-bit address, ACKs reads, serialises bytes supplied by a local ready/valid source and samples the master ACK/NACK.
- Sits beside I2C_slave on the shared SCL/SDA bus, clocked by the divided `clk` from the clock block.

---
 rtl/i2c_pkg.sv | 37 +++
 rtl/i2c_line_sync.sv | 68 ++++++
 rtl/i2c_slave_tx.sv | 182 ++++++++++++++++++
 tb/tb_i2c_slave_tx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target-side blocks (transmitter and the
// existing receiver): bus widths, the transmitter state encoding and the
// START/STOP bus-condition detectors so both paths decode the bus the same
// way.
// ---------------------------------------------------------------------------
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;
   localparam int BIT_CNT_W  = $clog2(I2C_BYTE_W);

   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(I2C_BYTE_W - 1);

   typedef enum logic [2:0] {
      TX_IDLE      = 3'd0,
      TX_ADDR      = 3'd1,
      TX_ADDR_ACK  = 3'd2,
      TX_BYTE      = 3'd3,
      TX_RX_ACK    = 3'd4,
      TX_WAIT_STOP = 3'd5
   } txState_e;

   // START: SDA falls while SCL stays high across both samples.
   function automatic logic isStart(input logic sclPrev, input logic sclNow,
                                    input logic sdaPrev, input logic sdaNow);
      return sclPrev & sclNow & sdaPrev & ~sdaNow;
   endfunction

   // STOP: SDA rises while SCL stays high across both samples.
   function automatic logic isStop(input logic sclPrev, input logic sclNow,
                                   input logic sdaPrev, input logic sdaNow);
      return sclPrev & sclNow & ~sdaPrev & sdaNow;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Brings the asynchronous SCL/SDA bus lines into the clk domain and turns
// them into single-cycle event strobes.
//   clk, rst      : system clock, synchronous active-high reset
//   scl_i, sda_i  : raw bus lines
//   sda_o         : synchronised SDA level, aligned with the strobes below
//   scl_rise_o    : SCL rising edge seen
//   scl_fall_o    : SCL falling edge seen
//   start_det_o   : START condition seen
//   stop_det_o    : STOP condition seen
// Edges come from the 2nd and 3rd flop stages and are registered, so an
// event on the pins appears on the strobes three clk edges later.
// ---------------------------------------------------------------------------
module i2c_line_sync
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [2:0] sclSync_q;
   logic [2:0] sdaSync_q;
   logic       sdaLevel_q;
   logic       sclRise_q;
   logic       sclFall_q;
   logic       startDet_q;
   logic       stopDet_q;

   // Shift both lines through a three-deep chain: stages 0/1 resolve
   // metastability, stage 2 holds the previous synchronised value so edges
   // can be found. Everything resets to the idle-high bus so leaving reset
   // never fakes an edge. The strobes are registered so downstream logic
   // sees clean single-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclSync_q  <= 3'b111;
         sdaSync_q  <= 3'b111;
         sdaLevel_q <= 1'b1;
         sclRise_q  <= 1'b0;
         sclFall_q  <= 1'b0;
         startDet_q <= 1'b0;
         stopDet_q  <= 1'b0;
      end else begin
         sclSync_q  <= {sclSync_q[1:0], scl_i};
         sdaSync_q  <= {sdaSync_q[1:0], sda_i};
         sdaLevel_q <= sdaSync_q[1];
         sclRise_q  <= sclSync_q[1] & ~sclSync_q[2];
         sclFall_q  <= ~sclSync_q[1] & sclSync_q[2];
         startDet_q <= isStart(sclSync_q[2], sclSync_q[1], sdaSync_q[2], sdaSync_q[1]);
         stopDet_q  <= isStop(sclSync_q[2], sclSync_q[1], sdaSync_q[2], sdaSync_q[1]);
      end
   end

   assign sda_o       = sdaLevel_q;
   assign scl_rise_o  = sclRise_q;
   assign scl_fall_o  = sclFall_q;
   assign start_det_o = startDet_q;
   assign stop_det_o  = stopDet_q;

endmodule

// File: rtl/i2c_slave_tx.sv
// ---------------------------------------------------------------------------
// i2c_slave_tx
// I2C target transmitter: answers master reads addressed to SLAVE_ADDR by
// shifting bytes from a local ready/valid source onto the open-drain SDA.
//   clk, rst  : system clock (>= 8x SCL), synchronous active-high reset
//   SCL       : bus clock from the master (input only, no stretching)
//   SDA       : open-drain data, only ever driven 0 or released
//   tx_data   : next byte to send, sampled only when a byte is loaded
//   tx_valid  : tx_data holds a byte
//   tx_ready  : pulse, tx_data was consumed
//   busy      : address matched, read in progress until STOP/NACK
//   byte_done : pulse after each byte's ACK/NACK bit is sampled
//   nack      : pulse with byte_done when the master NACKed
//   underrun  : pulse when FILL_BYTE was loaded for lack of data
// ---------------------------------------------------------------------------
module i2c_slave_tx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h3C,
   parameter logic [I2C_BYTE_W-1:0] FILL_BYTE  = 8'hFF
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  SCL,
   inout  wire                   SDA,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  byte_done,
   output logic                  nack,
   output logic                  underrun
);

   logic sdaIn;
   logic sclRise;
   logic sclFall;
   logic startDet;
   logic stopDet;

   txState_e                state_q;
   logic [BIT_CNT_W-1:0]    bitCnt_q;
   logic [I2C_BYTE_W-1:0]   shift_q;
   logic                    sdaLow_q;
   logic                    busy_q;
   logic                    txReady_q;
   logic                    byteDone_q;
   logic                    nack_q;
   logic                    underrun_q;
   logic [I2C_BYTE_W-1:0]   loadByte;

   i2c_line_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .scl_i       (SCL),
      .sda_i       (SDA),
      .sda_o       (sdaIn),
      .scl_rise_o  (sclRise),
      .scl_fall_o  (sclFall),
      .start_det_o (startDet),
      .stop_det_o  (stopDet)
   );

   // The byte taken at a load point: local data when offered, otherwise the
   // fill pattern so the master still gets a well-defined byte.
   assign loadByte = tx_valid ? tx_data : FILL_BYTE;

   // Whole protocol engine. START/STOP are checked before any SCL edge so a
   // bus condition always wins, wherever the engine happens to be. SDA is
   // only ever changed in response to a detected SCL fall (or a bus
   // condition / reset, which only release it), which keeps the line stable
   // while SCL is high. In ADDR_ACK and RX_ACK the bit counter doubles as a
   // phase flag: 0 = waiting for the first event, 1 = second phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         sdaLow_q   <= 1'b0;
         busy_q     <= 1'b0;
         txReady_q  <= 1'b0;
         byteDone_q <= 1'b0;
         nack_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         txReady_q  <= 1'b0;
         byteDone_q <= 1'b0;
         nack_q     <= 1'b0;
         underrun_q <= 1'b0;
         if (startDet) begin
            state_q  <= TX_ADDR;
            bitCnt_q <= '0;
            shift_q  <= '0;
            sdaLow_q <= 1'b0;
            busy_q   <= 1'b0;
         end else if (stopDet) begin
            state_q  <= TX_IDLE;
            sdaLow_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               TX_ADDR: begin
                  if (sclRise) begin
                     shift_q <= {shift_q[I2C_BYTE_W-2:0], sdaIn};
                     if (bitCnt_q == LAST_BIT) begin
                        bitCnt_q <= '0;
                        if ({shift_q[I2C_BYTE_W-2:0], sdaIn} == {SLAVE_ADDR, 1'b1})
                           state_q <= TX_ADDR_ACK;
                        else
                           state_q <= TX_WAIT_STOP;
                     end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                     end
                  end
               end
               TX_ADDR_ACK: begin
                  if (sclFall) begin
                     if (bitCnt_q == '0) begin
                        sdaLow_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        shift_q    <= loadByte;
                        txReady_q  <= tx_valid;
                        underrun_q <= ~tx_valid;
                        bitCnt_q   <= BIT_CNT_W'(1);
                     end else begin
                        state_q  <= TX_BYTE;
                        bitCnt_q <= '0;
                        sdaLow_q <= ~shift_q[I2C_BYTE_W-1];
                     end
                  end
               end
               TX_BYTE: begin
                  if (sclFall) begin
                     if (bitCnt_q == LAST_BIT) begin
                        state_q  <= TX_RX_ACK;
                        bitCnt_q <= '0;
                        sdaLow_q <= 1'b0;
                     end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                        shift_q  <= {shift_q[I2C_BYTE_W-2:0], 1'b0};
                        sdaLow_q <= ~shift_q[I2C_BYTE_W-2];
                     end
                  end
               end
               TX_RX_ACK: begin
                  if (bitCnt_q == '0) begin
                     if (sclRise) begin
                        byteDone_q <= 1'b1;
                        if (sdaIn) begin
                           nack_q  <= 1'b1;
                           busy_q  <= 1'b0;
                           state_q <= TX_WAIT_STOP;
                        end else begin
                           bitCnt_q <= BIT_CNT_W'(1);
                        end
                     end
                  end else if (sclFall) begin
                     shift_q    <= loadByte;
                     txReady_q  <= tx_valid;
                     underrun_q <= ~tx_valid;
                     sdaLow_q   <= ~loadByte[I2C_BYTE_W-1];
                     bitCnt_q   <= '0;
                     state_q    <= TX_BYTE;
                  end
               end
               default: begin
                  sdaLow_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign SDA       = sdaLow_q ? 1'b0 : 1'bz;
   assign tx_ready  = txReady_q;
   assign busy      = busy_q;
   assign byte_done = byteDone_q;
   assign nack      = nack_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2c_slave_tx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_tx
// Bit-banged I2C master plus a byte source and scoreboard around the
// i2c_slave_tx target. Bytes offered to the source are pushed to an expected
// queue; every byte read back off the bus is popped and compared.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_tx;

   logic       clk;
   logic       rst;
   logic       SCL;
   wire        SDA;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       byte_done;
   logic       nack;
   logic       underrun;

   logic       mDrvLow;

   int vectors;
   int miscompares;

   logic [7:0] srcQ[$];
   logic [7:0] expQ[$];

   int txReadyCnt;
   int byteDoneCnt;
   int nackCnt;
   int underrunCnt;
   int dutLowCnt;
   int busyCnt;
   int orphanNackCnt;

   i2c_slave_tx #(
      .SLAVE_ADDR (7'h3C),
      .FILL_BYTE  (8'hFF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .SCL       (SCL),
      .SDA       (SDA),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .byte_done (byte_done),
      .nack      (nack),
      .underrun  (underrun)
   );

   // Open-drain bus: master only pulls low, pull-up supplies the high level.
   assign SDA = mDrvLow ? 1'b0 : 1'bz;
   pullup (SDA);

   // Free-running 100 MHz system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte source and pulse monitor, sampled 1 ns after each rising edge.
   // The source pops a byte whenever the DUT reports it consumed one.
   initial begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (tx_ready) begin
            txReadyCnt++;
            if (srcQ.size() != 0) void'(srcQ.pop_front());
         end
         if (byte_done) byteDoneCnt++;
         if (nack) nackCnt++;
         if (nack && !byte_done) orphanNackCnt++;
         if (underrun) underrunCnt++;
         if (busy) busyCnt++;
         if (!mDrvLow && SDA === 1'b0) dutLowCnt++;
         tx_valid = (srcQ.size() != 0);
         tx_data  = (srcQ.size() != 0) ? srcQ[0] : 8'h00;
      end
   end

   task automatic pushByte(input logic [7:0] b);
      srcQ.push_back(b);
      expQ.push_back(b);
   endtask

   // One SCL period. sdaVal = 1 releases SDA (for reading), 0 pulls it low.
   task automatic clockBit(input logic sdaVal, output logic sampled);
      #20 mDrvLow = ~sdaVal;
      #80 SCL = 1'b1;
      #50 sampled = (SDA === 1'b0) ? 1'b0 : 1'b1;
      #50 SCL = 1'b0;
   endtask

   // START from idle, or repeated START when SCL is currently low.
   task automatic startCond();
      if (SCL == 1'b0) begin
         #20 mDrvLow = 1'b0;
         #80 SCL = 1'b1;
      end
      #100 mDrvLow = 1'b1;
      #100 SCL = 1'b0;
   endtask

   task automatic stopCond();
      #20 mDrvLow = 1'b1;
      #80 SCL = 1'b1;
      #100 mDrvLow = 1'b0;
      #200;
   endtask

   task automatic sendAddr(input logic [6:0] addr, input logic rw, output logic ack);
      logic [7:0] b;
      logic       dummy;
      b = {addr, rw};
      for (int i = 7; i >= 0; i--) clockBit(b[i], dummy);
      clockBit(1'b1, ack);
   endtask

   // Read one byte, answer with masterAck (0 = ACK, 1 = NACK), check it
   // against the head of the expected queue.
   task automatic readByteCheck(input logic masterAck, input string name);
      logic [7:0] got;
      logic [7:0] exp;
      logic       dummy;
      for (int i = 7; i >= 0; i--) clockBit(1'b1, got[i]);
      clockBit(masterAck, dummy);
      vectors++;
      if (expQ.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL %s: got byte %02h, expected queue empty", name, got);
      end else begin
         exp = expQ.pop_front();
         if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got byte %02h, expected %02h", name, got, exp);
         end
      end
   endtask

   task automatic applyReset();
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // Outputs and SDA after reset.
   task automatic test_reset();
      applyReset();
      vectors++;
      if ({tx_ready, busy, byte_done, nack, underrun} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %b, expected 00000",
                  {tx_ready, busy, byte_done, nack, underrun});
      end
      vectors++;
      if (SDA !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_sda: got %b, expected 1", SDA);
      end
   endtask

   // One byte 0xA5, master NACKs.
   task automatic test_single_read();
      logic ack;
      int   r0, b0, n0;
      r0 = txReadyCnt; b0 = byteDoneCnt; n0 = nackCnt;
      pushByte(8'hA5);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_addr_ack: got %b, expected 0", ack);
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL single_busy_set: got %b, expected 1", busy);
      end
      readByteCheck(1'b1, "single_byte");
      #100;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_busy_clear: got %b, expected 0", busy);
      end
      vectors++;
      if ({txReadyCnt - r0, byteDoneCnt - b0, nackCnt - n0} !== {32'd1, 32'd1, 32'd1}) begin
         miscompares++;
         $display("[TB] FAIL single_pulses: got ready=%0d done=%0d nack=%0d, expected 1 1 1",
                  txReadyCnt - r0, byteDoneCnt - b0, nackCnt - n0);
      end
      stopCond();
   endtask

   // Three bytes, ACK ACK NACK.
   task automatic test_burst();
      logic ack;
      int   r0, b0, n0;
      r0 = txReadyCnt; b0 = byteDoneCnt; n0 = nackCnt;
      pushByte(8'h11);
      pushByte(8'h22);
      pushByte(8'h33);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL burst_addr_ack: got %b, expected 0", ack);
      end
      readByteCheck(1'b0, "burst_byte0");
      vectors++;
      if (nackCnt - n0 !== 0) begin
         miscompares++;
         $display("[TB] FAIL burst_early_nack: got %0d nack pulses, expected 0", nackCnt - n0);
      end
      readByteCheck(1'b0, "burst_byte1");
      readByteCheck(1'b1, "burst_byte2");
      #100;
      vectors++;
      if ({txReadyCnt - r0, byteDoneCnt - b0, nackCnt - n0} !== {32'd3, 32'd3, 32'd1}) begin
         miscompares++;
         $display("[TB] FAIL burst_pulses: got ready=%0d done=%0d nack=%0d, expected 3 3 1",
                  txReadyCnt - r0, byteDoneCnt - b0, nackCnt - n0);
      end
      stopCond();
   endtask

   // Wrong address, and right address with write direction.
   task automatic test_mismatch();
      logic ack;
      int   l0, y0;
      logic [1:0] rwSel;
      logic [6:0] addrSel [2];
      addrSel[0] = 7'h3D;
      addrSel[1] = 7'h3C;
      rwSel = 2'b01;
      for (int k = 0; k < 2; k++) begin
         l0 = dutLowCnt; y0 = busyCnt;
         startCond();
         sendAddr(addrSel[k], rwSel[k], ack);
         vectors++;
         if (ack !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mismatch_ack_%0d: got %b, expected 1", k, ack);
         end
         stopCond();
         vectors++;
         if (dutLowCnt - l0 !== 0 || busyCnt - y0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL mismatch_quiet_%0d: got sdaLow=%0d busy=%0d cycles, expected 0 0",
                     k, dutLowCnt - l0, busyCnt - y0);
         end
      end
   endtask

   // No data available at load time.
   task automatic test_underrun();
      logic ack;
      int   r0, u0;
      r0 = txReadyCnt; u0 = underrunCnt;
      expQ.push_back(8'hFF);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      readByteCheck(1'b1, "underrun_byte");
      vectors++;
      if (underrunCnt - u0 !== 1 || txReadyCnt - r0 !== 0) begin
         miscompares++;
         $display("[TB] FAIL underrun_pulses: got underrun=%0d ready=%0d, expected 1 0",
                  underrunCnt - u0, txReadyCnt - r0);
      end
      stopCond();
   endtask

   // Repeated START after 4 data bits, then a fresh read.
   task automatic test_repeated_start();
      logic       ack;
      logic [3:0] part;
      logic [7:0] exp;
      int         b0;
      b0 = byteDoneCnt;
      pushByte(8'h5F);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      for (int i = 3; i >= 0; i--) clockBit(1'b1, part[i]);
      exp = expQ.pop_front();
      vectors++;
      if (part !== exp[7:4]) begin
         miscompares++;
         $display("[TB] FAIL rstart_partial: got %h, expected %h", part, exp[7:4]);
      end
      pushByte(8'hC3);
      startCond();
      vectors++;
      if (byteDoneCnt - b0 !== 0) begin
         miscompares++;
         $display("[TB] FAIL rstart_no_done: got %0d byte_done, expected 0", byteDoneCnt - b0);
      end
      sendAddr(7'h3C, 1'b1, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rstart_addr_ack: got %b, expected 0", ack);
      end
      readByteCheck(1'b1, "rstart_byte");
      stopCond();
   endtask

   // Reset while the DUT pulls SDA low for a 0 data bit.
   task automatic test_reset_mid_byte();
      logic       ack;
      logic [7:0] dropped;
      pushByte(8'h12);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      #80;
      vectors++;
      if (SDA !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_driven: got SDA %b, expected 0", SDA);
      end
      dropped = expQ.pop_front();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (SDA !== 1'b1 || {tx_ready, busy, byte_done, nack, underrun} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_release: got SDA %b outputs %b, expected 1 00000",
                  SDA, {tx_ready, busy, byte_done, nack, underrun});
      end
      @(negedge clk) rst = 1'b0;
      stopCond();
      pushByte(8'hA5);
      startCond();
      sendAddr(7'h3C, 1'b1, ack);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midreset_next_ack: got %b, expected 0 (dropped %02h)", ack, dropped);
      end
      readByteCheck(1'b1, "midreset_next_byte");
      stopCond();
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      txReadyCnt    = 0;
      byteDoneCnt   = 0;
      nackCnt       = 0;
      underrunCnt   = 0;
      dutLowCnt     = 0;
      busyCnt       = 0;
      orphanNackCnt = 0;
      rst           = 1'b1;
      SCL           = 1'b1;
      mDrvLow       = 1'b0;

      test_reset();
      test_single_read();
      test_burst();
      test_mismatch();
      test_underrun();
      test_repeated_start();
      test_reset_mid_byte();

      vectors++;
      if (orphanNackCnt !== 0) begin
         miscompares++;
         $display("[TB] FAIL nack_alignment: got %0d nack pulses without byte_done, expected 0",
                  orphanNackCnt);
      end
      vectors++;
      if (expQ.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d bytes left, expected 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
